// File: rtl/accumulator_bank.sv
// -----------------------------------------------------------------------------
// accumulator_bank
//
// Bank of DEPTH accumulator registers, WIDTH bits each, sitting between the
// operand bus and the ALU. The register selected by WrSel can be loaded,
// accumulated into (add/sub) or shifted right in place. Carry and Zero flags
// are registered and describe the last executed operation. Two independent
// combinational read ports feed the ALU A and B operands.
//
// Optional build macro: ACCUM_SATURATE_EN
//   defined   : ADD that carries writes all-ones, SUB that borrows writes zero
//   undefined : ADD/SUB wrap modulo 2**WIDTH
//
// Ports
//   MainClock  in   1      system clock, rising edge
//   ClearB     in   1      asynchronous active-low reset
//   Latch      in   1      execute Op on register WrSel this edge
//   ClrReg     in   1      synchronous clear of register WrSel (beats Latch)
//   Op         in   2      00 LOAD, 01 ADD, 10 SUB, 11 SHR
//   WrSel      in   SELW   target register index
//   DataIn     in   WIDTH  operand / load value
//   RdSelA     in   SELW   read index for AluA
//   RdSelB     in   SELW   read index for AluB
//   AluA       out  WIDTH  register RdSelA (combinational, 0 if out of range)
//   AluB       out  WIDTH  register RdSelB (combinational, 0 if out of range)
//   Carry      out  1      carry / borrow / shift-out of last executed op
//   Zero       out  1      result of last executed op was zero
//   ValidMask  out  DEPTH  bit i set once register i has been written
// -----------------------------------------------------------------------------
module accumulator_bank #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int SELW  = 2
) (
    input  logic             MainClock,
    input  logic             ClearB,
    input  logic             Latch,
    input  logic             ClrReg,
    input  logic [1:0]       Op,
    input  logic [SELW-1:0]  WrSel,
    input  logic [WIDTH-1:0] DataIn,
    input  logic [SELW-1:0]  RdSelA,
    input  logic [SELW-1:0]  RdSelB,
    output logic [WIDTH-1:0] AluA,
    output logic [WIDTH-1:0] AluB,
    output logic             Carry,
    output logic             Zero,
    output logic [DEPTH-1:0] ValidMask
);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_SHR  = 2'b11;

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic             r_carry;
    logic             r_zero;
    logic [DEPTH-1:0] r_valid;

    logic             w_wr_ok;
    logic [WIDTH-1:0] w_cur;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_res_carry;
    logic [WIDTH-1:0] w_next;
    logic             w_next_carry;
    logic [WIDTH-1:0] w_rd_a;
    logic [WIDTH-1:0] w_rd_b;

    // Write index in range; out-of-range writes leave every piece of state alone.
    assign w_wr_ok = (32'(WrSel) < DEPTH);

    // Read ports: AND-OR mux over the array, so an index with no matching
    // register naturally reads as zero.
    always_comb begin
        w_rd_a = {WIDTH{1'b0}};
        w_rd_b = {WIDTH{1'b0}};
        w_cur  = {WIDTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            w_rd_a = w_rd_a | ({WIDTH{RdSelA == SELW'(i)}} & r_regs[i]);
            w_rd_b = w_rd_b | ({WIDTH{RdSelB == SELW'(i)}} & r_regs[i]);
            w_cur  = w_cur  | ({WIDTH{WrSel  == SELW'(i)}} & r_regs[i]);
        end
    end

    assign AluA = w_rd_a;
    assign AluB = w_rd_b;

    // Both arithmetic results carry one extra bit: carry-out for ADD, and for
    // SUB the top bit is set exactly when DataIn > current value (borrow).
    assign w_sum  = {1'b0, w_cur} + {1'b0, DataIn};
    assign w_diff = {1'b0, w_cur} - {1'b0, DataIn};

    // Operation result and carry for the selected register.
    always_comb begin
        w_res       = w_cur;
        w_res_carry = 1'b0;
        case (Op)
            OP_LOAD: begin
                w_res       = DataIn;
                w_res_carry = 1'b0;
            end
            OP_ADD: begin
                w_res_carry = w_sum[WIDTH];
`ifdef ACCUM_SATURATE_EN
                if (w_sum[WIDTH]) begin
                    w_res = {WIDTH{1'b1}};
                end else begin
                    w_res = w_sum[WIDTH-1:0];
                end
`else
                w_res = w_sum[WIDTH-1:0];
`endif
            end
            OP_SUB: begin
                w_res_carry = w_diff[WIDTH];
`ifdef ACCUM_SATURATE_EN
                if (w_diff[WIDTH]) begin
                    w_res = {WIDTH{1'b0}};
                end else begin
                    w_res = w_diff[WIDTH-1:0];
                end
`else
                w_res = w_diff[WIDTH-1:0];
`endif
            end
            OP_SHR: begin
                w_res       = {1'b0, w_cur[WIDTH-1:1]};
                w_res_carry = w_cur[0];
            end
            default: begin
                w_res       = w_cur;
                w_res_carry = 1'b0;
            end
        endcase
    end

    // ClrReg overrides whatever Op would have produced.
    always_comb begin
        w_next       = w_res;
        w_next_carry = w_res_carry;
        if (ClrReg) begin
            w_next       = {WIDTH{1'b0}};
            w_next_carry = 1'b0;
        end else begin
            w_next       = w_res;
            w_next_carry = w_res_carry;
        end
    end

    // Register array, flags and written-mask update.
    always_ff @(posedge MainClock or negedge ClearB) begin
        if (!ClearB) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= {WIDTH{1'b0}};
            end
            r_carry <= 1'b0;
            r_zero  <= 1'b1;
            r_valid <= {DEPTH{1'b0}};
        end else if (w_wr_ok && (ClrReg || Latch)) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (WrSel == SELW'(i)) begin
                    r_regs[i]  <= w_next;
                    r_valid[i] <= 1'b1;
                end
            end
            r_carry <= w_next_carry;
            r_zero  <= (w_next == {WIDTH{1'b0}});
        end
    end

    assign Carry     = r_carry;
    assign Zero      = r_zero;
    assign ValidMask = r_valid;

endmodule

// File: tb/tb_accumulator_bank.sv
// -----------------------------------------------------------------------------
// tb_accumulator_bank
//
// Directed bench for accumulator_bank (WIDTH=4, DEPTH=4). The driver pushes
// hand-computed expected outputs into a queue; a monitor process pops and
// compares them on the falling clock edge, or immediately when the driver
// toggles chk_tog (used to observe the asynchronous reset without a clock edge).
// -----------------------------------------------------------------------------
module tb_accumulator_bank;

`ifdef ACCUM_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    localparam logic [1:0] LD  = 2'b00;
    localparam logic [1:0] ADD = 2'b01;
    localparam logic [1:0] SUB = 2'b10;
    localparam logic [1:0] SHR = 2'b11;

    logic       MainClock = 1'b0;
    logic       ClearB    = 1'b0;
    logic       Latch     = 1'b0;
    logic       ClrReg    = 1'b0;
    logic [1:0] Op        = 2'b00;
    logic [1:0] WrSel     = 2'd0;
    logic [3:0] DataIn    = 4'h0;
    logic [1:0] RdSelA    = 2'd0;
    logic [1:0] RdSelB    = 2'd0;
    logic [3:0] AluA;
    logic [3:0] AluB;
    logic       Carry;
    logic       Zero;
    logic [3:0] ValidMask;

    accumulator_bank #(.WIDTH(4), .DEPTH(4), .SELW(2)) dut (
        .MainClock (MainClock),
        .ClearB    (ClearB),
        .Latch     (Latch),
        .ClrReg    (ClrReg),
        .Op        (Op),
        .WrSel     (WrSel),
        .DataIn    (DataIn),
        .RdSelA    (RdSelA),
        .RdSelB    (RdSelB),
        .AluA      (AluA),
        .AluB      (AluB),
        .Carry     (Carry),
        .Zero      (Zero),
        .ValidMask (ValidMask)
    );

    always #5 MainClock = ~MainClock;

    typedef struct {
        string      name;
        logic [3:0] a;
        logic [3:0] b;
        logic       c;
        logic       z;
        logic [3:0] vm;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_errors = 0;
    logic chk_tog  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic push(input string nm, input logic [3:0] a, input logic [3:0] b,
                        input logic c, input logic z, input logic [3:0] vm);
        exp_t x;
        x.name = nm; x.a = a; x.b = b; x.c = c; x.z = z; x.vm = vm;
        exp_q.push_back(x);
    endtask

    // Monitor: compare every queued expectation against the live outputs.
    always @(negedge MainClock or chk_tog) begin
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({e.name, ".AluA"},      32'(AluA),      32'(e.a));
            chk({e.name, ".AluB"},      32'(AluB),      32'(e.b));
            chk({e.name, ".Carry"},     32'(Carry),     32'(e.c));
            chk({e.name, ".Zero"},      32'(Zero),      32'(e.z));
            chk({e.name, ".ValidMask"}, 32'(ValidMask), 32'(e.vm));
        end
    end

    task automatic cyc();
        @(posedge MainClock);
        #1;
    endtask

    task automatic drive(input logic l, input logic c, input logic [1:0] o,
                         input logic [1:0] w, input logic [3:0] d,
                         input logic [1:0] ra, input logic [1:0] rb);
        Latch = l; ClrReg = c; Op = o; WrSel = w; DataIn = d; RdSelA = ra; RdSelB = rb;
    endtask

    // Watchdog so the run can never hang.
    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] r0_add;
        logic [3:0] r3_sub;
        logic       z_sub;
        logic [3:0] r2_sub;
        logic       z_r2;
        r0_add = SAT ? 4'hF : 4'h2;
        r3_sub = SAT ? 4'h0 : 4'hF;
        z_sub  = SAT ? 1'b1 : 1'b0;
        r2_sub = SAT ? 4'h0 : 4'hF;
        z_r2   = SAT ? 1'b1 : 1'b0;

        // Reset held: inputs ignored, outputs at reset values.
        drive(1'b1, 1'b0, LD, 2'd0, 4'h9, 2'd0, 2'd0);
        cyc(); cyc();
        push("rst_init", 4'h0, 4'h0, 1'b0, 1'b1, 4'b0000);

        // LOAD on the release edge; same-cycle read returns the old value.
        cyc(); ClearB = 1'b1;
        drive(1'b1, 1'b0, LD, 2'd2, 4'h5, 2'd2, 2'd0);
        push("load_same", 4'h0, 4'h0, 1'b0, 1'b1, 4'b0000);
        cyc(); drive(1'b1, 1'b0, LD, 2'd0, 4'hC, 2'd2, 2'd0);
        push("load_next", 4'h5, 4'h0, 1'b0, 1'b0, 4'b0100);

        // ADD overflow on R0.
        cyc(); drive(1'b1, 1'b0, ADD, 2'd0, 4'h6, 2'd0, 2'd2);
        push("add_pre", 4'hC, 4'h5, 1'b0, 1'b0, 4'b0101);
        cyc(); drive(1'b1, 1'b0, LD, 2'd3, 4'h3, 2'd0, 2'd2);
        push("add_ovf", r0_add, 4'h5, 1'b1, 1'b0, 4'b0101);

        // SUB to zero, then borrow.
        cyc(); drive(1'b1, 1'b0, SUB, 2'd3, 4'h3, 2'd3, 2'd0);
        push("sub_pre", 4'h3, r0_add, 1'b0, 1'b0, 4'b1101);
        cyc(); drive(1'b1, 1'b0, SUB, 2'd3, 4'h1, 2'd3, 2'd0);
        push("sub_zero", 4'h0, r0_add, 1'b0, 1'b1, 4'b1101);
        cyc(); drive(1'b1, 1'b0, LD, 2'd1, 4'hB, 2'd3, 2'd0);
        push("sub_borrow", r3_sub, r0_add, 1'b1, z_sub, 4'b1101);

        // SHR, then ClrReg beating a simultaneous LOAD.
        cyc(); drive(1'b1, 1'b0, SHR, 2'd1, 4'hF, 2'd1, 2'd3);
        push("shr_pre", 4'hB, r3_sub, 1'b0, 1'b0, 4'b1111);
        cyc(); drive(1'b1, 1'b1, LD, 2'd1, 4'h7, 2'd1, 2'd3);
        push("shr", 4'h5, r3_sub, 1'b1, 1'b0, 4'b1111);
        cyc(); drive(1'b1, 1'b0, LD, 2'd0, 4'hA, 2'd1, 2'd3);
        push("clr_prio", 4'h0, r3_sub, 1'b0, 1'b1, 4'b1111);

        // Set up dual read: R0=A, R3=6, then a borrowing SUB on R2 (5-6).
        cyc(); drive(1'b1, 1'b0, LD, 2'd3, 4'h6, 2'd0, 2'd3);
        cyc(); drive(1'b1, 1'b0, SUB, 2'd2, 4'h6, 2'd0, 2'd3);

        // Hold for 5 edges with junk Op/DataIn and Latch low.
        cyc(); drive(1'b0, 1'b0, ADD, 2'd0, 4'h9, 2'd0, 2'd3);
        push("hold_entry_r2", 4'hA, 4'h6, 1'b1, z_r2, 4'b1111);
        for (int i = 0; i < 5; i++) begin
            cyc();
            push("hold", 4'hA, 4'h6, 1'b1, z_r2, 4'b1111);
        end
        cyc(); drive(1'b0, 1'b0, ADD, 2'd0, 4'h9, 2'd2, 2'd3);
        push("hold_r2", r2_sub, 4'h6, 1'b1, z_r2, 4'b1111);

        // Accumulation chain on R1: 0+3+4+2 = 9.
        cyc(); drive(1'b1, 1'b0, ADD, 2'd1, 4'h3, 2'd1, 2'd3);
        cyc(); drive(1'b1, 1'b0, ADD, 2'd1, 4'h4, 2'd1, 2'd3);
        push("chain3", 4'h3, 4'h6, 1'b0, 1'b0, 4'b1111);
        cyc(); drive(1'b1, 1'b0, ADD, 2'd1, 4'h2, 2'd1, 2'd3);
        push("chain7", 4'h7, 4'h6, 1'b0, 1'b0, 4'b1111);
        cyc(); drive(1'b1, 1'b0, ADD, 2'd1, 4'h1, 2'd1, 2'd3);
        push("chain9", 4'h9, 4'h6, 1'b0, 1'b0, 4'b1111);

        // Asynchronous reset mid-chain, observed before any further clock edge.
        @(negedge MainClock); #1;
        ClearB = 1'b0;
        #1;
        push("rst_async", 4'h0, 4'h0, 1'b0, 1'b1, 4'b0000);
        chk_tog = ~chk_tog;

        // Inputs ignored while reset is held.
        cyc(); drive(1'b1, 1'b1, LD, 2'd1, 4'hF, 2'd1, 2'd3);
        push("rst_hold", 4'h0, 4'h0, 1'b0, 1'b1, 4'b0000);

        // Release and execute on the first edge.
        cyc(); ClearB = 1'b1;
        drive(1'b1, 1'b0, LD, 2'd1, 4'h9, 2'd1, 2'd3);
        push("rst_release", 4'h0, 4'h0, 1'b0, 1'b1, 4'b0000);
        cyc(); drive(1'b0, 1'b0, LD, 2'd1, 4'h0, 2'd1, 2'd3);
        push("post_rst", 4'h9, 4'h0, 1'b0, 1'b0, 4'b0010);

        cyc(); cyc();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/accumulator_bank.md
Name: accumulator_bank

Overview:
- Parametrised successor to the single 4-bit ALU operand latch.
- Holds DEPTH accumulator registers, each WIDTH bits, between the operand bus and the ALU.
- Each register can be loaded, accumulated into (add/sub) or shifted in place, with registered Carry/Zero flags.
- Two independent read ports drive the ALU A and B operand inputs.

Parameters:
- WIDTH, 4, bit width of each accumulator register and of DataIn/AluA/AluB.
- DEPTH, 4, number of accumulator registers (2..16).
- SELW, 2, width of the register-select inputs; must satisfy 2**SELW >= DEPTH.

Ports:
- MainClock  input  1  system clock; all state changes on its rising edge.
- ClearB  input  1  asynchronous active-low reset; clears all state immediately.
- Latch  input  1  execute enable; the operation in Op is applied to register WrSel this edge.
- ClrReg  input  1  synchronous clear of register WrSel; has priority over Latch.
- Op  input  2  operation: 00 LOAD, 01 ADD, 10 SUB, 11 SHR.
- WrSel  input  SELW  target register index.
- DataIn  input  WIDTH  operand / load value.
- RdSelA  input  SELW  read index for AluA.
- RdSelB  input  SELW  read index for AluB.
- AluA  output  WIDTH  contents of register RdSelA, combinational.
- AluB  output  WIDTH  contents of register RdSelB, combinational.
- Carry  output  1  registered carry/borrow/shift-out flag.
- Zero  output  1  registered flag, result of last executed operation == 0.
- ValidMask  output  DEPTH  bit i set once register i has been written since reset.

Behaviour:
- Reset (ClearB=0, asynchronous, no clock needed): all registers 0, Carry=0, Zero=1, ValidMask=0. While ClearB=0 all inputs are ignored. Release is synchronous to the next rising edge; the first operation can execute on that edge.
- Per rising edge, priority order:
  1. ClrReg: R[WrSel]<=0, Carry<=0, Zero<=1, ValidMask[WrSel]<=1.
  2. Latch: execute Op.
  3. Otherwise: hold all state.
- LOAD: R<=DataIn; Carry<=0.
- ADD: {c,r}=R+DataIn computed in WIDTH+1 bits; R<=r (mod 2^WIDTH); Carry<=c.
- SUB: r=R-DataIn mod 2^WIDTH; R<=r; Carry<=1 when DataIn>R (borrow), else 0.
- SHR: R<={0,R[WIDTH-1:1]} (logical); Carry<=R[0]; DataIn ignored.
- Flags for any executed op: Zero<=(new R==0); ValidMask[WrSel]<=1.
- Latency:
  - Written value is visible on AluA/AluB one edge after execution.
  - No write-to-read forwarding: a read of WrSel in the same cycle returns the pre-edge value.
- Reads are purely combinational from the register array. Indices >= DEPTH read as 0.
- WrSel >= DEPTH with ClrReg or Latch set: no register, flag or ValidMask change.
- Back-to-back ops on the same register each use the value updated at the previous edge (accumulation chains).
- ClearB asserted mid-chain: everything returns to the reset values above; partial results are discarded.

Optional Feature:
- Macro ACCUM_SATURATE_EN.
- Defined:
  - ADD that carries writes all-ones (2^WIDTH-1) instead of wrapping.
  - SUB that borrows writes 0.
  - Carry still reports the overflow/borrow; Zero reflects the saturated value.
  - LOAD and SHR are unchanged.
- Undefined: ADD/SUB wrap modulo 2^WIDTH as specified above.

Test Plan (WIDTH=4, DEPTH=4):
- Reset: ClearB=0 mid-sequence after R1=0x9 -> immediately AluA(RdSelA=1)=0x0, Carry=0, Zero=1, ValidMask=0000, with no clock edge.
- LOAD then read: LOAD 0x5 into R2, RdSelA=2 in the same cycle -> AluA=0x0 (old value); next cycle AluA=0x5, Zero=0, ValidMask=0100.
- ADD overflow: R0=0xC, ADD 0x6 -> R0=0x2, Carry=1. With ACCUM_SATURATE_EN -> R0=0xF, Carry=1.
- SUB borrow/zero:
  - R3=0x3, SUB 0x3 -> R3=0x0, Zero=1, Carry=0.
  - Then SUB 0x1 -> R3=0xF, Carry=1 (saturated build: 0x0, Zero=1, Carry=1).
- SHR and priority:
  - R1=0xB, SHR -> R1=0x5, Carry=1.
  - Then ClrReg=1 together with Latch=1, Op=LOAD 0x7 -> R1=0x0, Zero=1, Carry=0.
- Dual read / hold: R0=0xA, R3=0x6, RdSelA=0, RdSelB=3, Latch=0 for 5 edges -> AluA=0xA, AluB=0x6 stable, flags unchanged.
